// File: rtl/gfx_pkg.sv
// Shared graphics definitions: screen defaults, framebuffer address width,
// writer state encoding, the packed fragment record and the pixel address helper.
package gfx_pkg;

  localparam int DEFAULT_SCREEN_WIDTH  = 320;
  localparam int DEFAULT_SCREEN_HEIGHT = 240;
  localparam int DEFAULT_COLOR_W       = 8;
  localparam int FB_ADDR_W             = 17;

  localparam logic [31:0] ZB_CLEAR_VALUE = 32'd0;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } writer_state_e;

  typedef struct packed {
    logic [FB_ADDR_W-1:0]       addr;
    logic [31:0]                z;
    logic [DEFAULT_COLOR_W-1:0] color;
  } fragment_t;

  // Linear address y*width + x, wrapped to the framebuffer address width.
  function automatic logic [FB_ADDR_W-1:0] pixelAddr(input logic [15:0] x,
                                                     input logic [15:0] y,
                                                     input int width);
    return FB_ADDR_W'(y) * FB_ADDR_W'(width) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/fragment_writer_if.sv
// Framebuffer/zbuffer write port between fragment_writer (master) and the
// memory side (slave); zbuffer address and strobe always mirror the framebuffer.
interface fragment_writer_if #(
  parameter int COLOR_W = gfx_pkg::DEFAULT_COLOR_W
);

  logic [gfx_pkg::FB_ADDR_W-1:0] o_fb_addr;
  logic [COLOR_W-1:0]            o_fb_data;
  logic                          o_fb_we;
  logic                          i_fb_ready;
  logic [gfx_pkg::FB_ADDR_W-1:0] o_zb_addr;
  logic [31:0]                   o_zb_data;
  logic                          o_zb_we;

  modport master (
    output o_fb_addr, o_fb_data, o_fb_we, o_zb_addr, o_zb_data, o_zb_we,
    input  i_fb_ready
  );

  modport slave (
    input  o_fb_addr, o_fb_data, o_fb_we, o_zb_addr, o_zb_data, o_zb_we,
    output i_fb_ready
  );

endinterface

// File: rtl/fragment_fifo.sv
// Synchronous FIFO of packed fragments. The caller never pushes when full
// nor pops when empty; a push and a pop in the same cycle keep occupancy.
module fragment_fifo #(
  parameter type T     = gfx_pkg::fragment_t,
  parameter int  DEPTH = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (i_push) wrPtr_q <= wrPtr_q + 1'b1;
      if (i_pop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({i_push, i_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wrPtr_q] <= i_data;
  end

  assign o_data  = mem_q[rdPtr_q];
  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);

endmodule

// File: rtl/fragment_writer.sv
// Commits rasterizer fragments to framebuffer/zbuffer through a small FIFO and
// a one-entry output slot, with a full-screen clear sweep. Stats: FRAGMENT_WRITER_STATS_EN.
module fragment_writer
  import gfx_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
  parameter int FIFO_DEPTH    = 8,
  parameter int COLOR_W       = DEFAULT_COLOR_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic [COLOR_W-1:0]    i_clear_color,
  input  logic                  i_write,
  input  logic [31:0]           i_point,
  input  logic [31:0]           i_zdata,
  input  logic [COLOR_W-1:0]    i_color,
  fragment_writer_if.master     mem,
  output logic                  o_full,
  output logic                  o_overflow,
  output logic                  o_busy,
  output logic [31:0]           o_frag_count,
  output logic [31:0]           o_drop_count
);

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [31:0]          z;
    logic [COLOR_W-1:0]   color;
  } frag_t;

  logic [15:0]   pointX;
  logic [15:0]   pointY;
  logic          inBounds;
  logic          push;
  logic          pop;
  logic          drop;
  logic          accept;
  logic          slotFree;
  logic          fifoFull;
  logic          fifoEmpty;
  frag_t         fragIn;
  frag_t         fragHead;

  writer_state_e        state_q;
  logic                 clearPending_q;
  logic [COLOR_W-1:0]   clearColor_q;
  logic                 overflow_q;
  logic                 slotValid_q;
  logic [FB_ADDR_W-1:0] slotAddr_q;
  logic [COLOR_W-1:0]   slotColor_q;
  logic [31:0]          slotZ_q;

  assign pointX   = i_point[15:0];
  assign pointY   = i_point[31:16];
  // Off-screen fragments vanish here; they are neither queued nor drops.
  assign inBounds = ({16'd0, pointX} < 32'(SCREEN_WIDTH)) &&
                    ({16'd0, pointY} < 32'(SCREEN_HEIGHT));
  assign push     = i_write && inBounds && !fifoFull;
  assign drop     = i_write && inBounds && fifoFull;

  assign fragIn.addr  = pixelAddr(pointX, pointY, SCREEN_WIDTH);
  assign fragIn.z     = i_zdata;
  assign fragIn.color = i_color;

  assign accept   = slotValid_q && mem.i_fb_ready;
  assign slotFree = !slotValid_q || accept;
  assign pop      = (state_q == S_IDLE) && slotFree && !fifoEmpty;

  fragment_fifo #(
    .T     (frag_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (fragIn),
    .i_pop   (pop),
    .o_data  (fragHead),
    .o_full  (fifoFull),
    .o_empty (fifoEmpty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q        <= S_IDLE;
      clearPending_q <= 1'b0;
      clearColor_q   <= '0;
      overflow_q     <= 1'b0;
      slotValid_q    <= 1'b0;
      slotAddr_q     <= '0;
      slotColor_q    <= '0;
      slotZ_q        <= '0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      if (i_clear && !clearPending_q) begin
        clearPending_q <= 1'b1;
        clearColor_q   <= i_clear_color;
      end
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            slotValid_q <= 1'b1;
            slotAddr_q  <= fragHead.addr;
            slotColor_q <= fragHead.color;
            slotZ_q     <= fragHead.z;
          end else if (clearPending_q && fifoEmpty && slotFree) begin
            // The slot itself is the sweep counter for the clear.
            state_q     <= S_CLEAR;
            slotValid_q <= 1'b1;
            slotAddr_q  <= '0;
            slotColor_q <= clearColor_q;
            slotZ_q     <= ZB_CLEAR_VALUE;
          end else if (accept) begin
            slotValid_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (accept) begin
            if (slotAddr_q == LAST_ADDR) begin
              state_q        <= S_IDLE;
              slotValid_q    <= 1'b0;
              clearPending_q <= 1'b0;
            end else begin
              slotAddr_q <= slotAddr_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign mem.o_fb_addr = slotAddr_q;
  assign mem.o_fb_data = slotColor_q;
  assign mem.o_fb_we   = slotValid_q;
  assign mem.o_zb_addr = slotAddr_q;
  assign mem.o_zb_data = slotZ_q;
  assign mem.o_zb_we   = slotValid_q;

  assign o_full     = fifoFull;
  assign o_overflow = overflow_q;
  assign o_busy     = !fifoEmpty || clearPending_q || (state_q == S_CLEAR) || slotValid_q;

`ifdef FRAGMENT_WRITER_STATS_EN
  logic [31:0] fragCount_q;
  logic [31:0] fragCount_d;
  logic [31:0] dropCount_q;
  logic [31:0] dropCount_d;

  // Only slot contents written from S_IDLE are real fragments.
  always_comb begin
    fragCount_d = fragCount_q;
    dropCount_d = dropCount_q;
    if (accept && (state_q == S_IDLE) && (fragCount_q != '1)) fragCount_d = fragCount_q + 32'd1;
    if (drop && (dropCount_q != '1)) dropCount_d = dropCount_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fragCount_q <= '0;
      dropCount_q <= '0;
    end else begin
      fragCount_q <= fragCount_d;
      dropCount_q <= dropCount_d;
    end
  end

  assign o_frag_count = fragCount_q;
  assign o_drop_count = dropCount_q;
`else
  assign o_frag_count = '0;
  assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_fragment_writer.sv
// Directed self-checking bench for fragment_writer: reset, single write, stall,
// overflow, clear sweep, off-screen discard and reset during a clear.
module tb_fragment_writer;

  logic        clk = 1'b0;
  logic        rstN;
  logic        clear;
  logic [7:0]  clearColor;
  logic        write;
  logic [31:0] point;
  logic [31:0] zdata;
  logic [7:0]  color;
  logic        full;
  logic        overflow;
  logic        busy;
  logic [31:0] fragCount;
  logic [31:0] dropCount;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  fragment_writer_if #(.COLOR_W(8)) memBus();

  fragment_writer #(
    .SCREEN_WIDTH  (320),
    .SCREEN_HEIGHT (240),
    .FIFO_DEPTH    (8),
    .COLOR_W       (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_clear       (clear),
    .i_clear_color (clearColor),
    .i_write       (write),
    .i_point       (point),
    .i_zdata       (zdata),
    .i_color       (color),
    .mem           (memBus),
    .o_full        (full),
    .o_overflow    (overflow),
    .o_busy        (busy),
    .o_frag_count  (fragCount),
    .o_drop_count  (dropCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [15:0] y, input logic [15:0] x,
                               input logic [31:0] z, input logic [7:0] c);
    write = w;
    point = {y, x};
    zdata = z;
    color = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sweepErrs;
    int waitCycles;
    int strayWrites;

    sweepErrs   = 0;
    waitCycles  = 0;
    strayWrites = 0;
    rstN        = 1'b0;
    clear       = 1'b0;
    clearColor  = 8'h00;
    memBus.i_fb_ready = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0, 8'h00);

    // Reset with inputs toggling: nothing may leak through.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'(i % 2 == 0), 16'(i), 16'(i + 3), 32'(i * 7), 8'(i + 1));
      clear      = 1'(i % 2);
      clearColor = 8'hF0;
      tick();
      checkOutput("rst_we",       32'(memBus.o_fb_we),   32'd0);
      checkOutput("rst_zb_we",    32'(memBus.o_zb_we),   32'd0);
      checkOutput("rst_busy",     32'(busy),             32'd0);
      checkOutput("rst_full",     32'(full),             32'd0);
      checkOutput("rst_overflow", 32'(overflow),         32'd0);
      checkOutput("rst_addr",     32'(memBus.o_fb_addr), 32'd0);
      checkOutput("rst_zdata",    memBus.o_zb_data,      32'd0);
    end
    checkOutput("rst_frag_count", fragCount, 32'd0);
    checkOutput("rst_drop_count", dropCount, 32'd0);
    rstN  = 1'b1;
    clear = 1'b0;
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0, 8'h00);
    tick();
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

    // Single fragment at (5,2): address 2*320+5 = 645, visible two cycles later.
    applyStimulus(1'b1, 16'd2, 16'd5, 32'h0001_0000, 8'h3C);
    tick();
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0, 8'h00);
    checkOutput("single_we_n1",   32'(memBus.o_fb_we), 32'd0);
    checkOutput("single_busy_n1", 32'(busy),           32'd1);
    tick();
    checkOutput("single_we_n2",    32'(memBus.o_fb_we),   32'd1);
    checkOutput("single_zb_we_n2", 32'(memBus.o_zb_we),   32'd1);
    checkOutput("single_addr",     32'(memBus.o_fb_addr), 32'd645);
    checkOutput("single_zb_addr",  32'(memBus.o_zb_addr), 32'd645);
    checkOutput("single_data",     32'(memBus.o_fb_data), 32'h3C);
    checkOutput("single_zdata",    memBus.o_zb_data,      32'h0001_0000);
    tick();
    checkOutput("single_we_n3",   32'(memBus.o_fb_we), 32'd0);
    checkOutput("single_busy_n3", 32'(busy),           32'd0);

    // Backpressure: three fragments on line 0, memory stalled for five cycles.
    memBus.i_fb_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 16'd0, 16'(k), 32'(k), 8'(8'h10 + k));
      tick();
    end
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_we",   32'(memBus.o_fb_we),   32'd1);
      checkOutput("stall_addr", 32'(memBus.o_fb_addr), 32'd1);
      checkOutput("stall_data", 32'(memBus.o_fb_data), 32'h11);
      tick();
    end
    memBus.i_fb_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      checkOutput("drain_we",    32'(memBus.o_fb_we),   32'd1);
      checkOutput("drain_addr",  32'(memBus.o_fb_addr), 32'(k));
      checkOutput("drain_zdata", memBus.o_zb_data,      32'(k));
      tick();
    end
    checkOutput("drain_done_we", 32'(memBus.o_fb_we), 32'd0);

    // Overflow: ten fragments into a stalled writer; one in the slot, eight queued, one dropped.
    memBus.i_fb_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 16'd1, 16'(10 + k), 32'(100 + k), 8'(k));
      tick();
    end
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0, 8'h00);
    checkOutput("ovf_full",     32'(full),             32'd1);
    checkOutput("ovf_overflow", 32'(overflow),         32'd1);
    checkOutput("ovf_slot_adr", 32'(memBus.o_fb_addr), 32'd330);
`ifdef FRAGMENT_WRITER_STATS_EN
    checkOutput("ovf_drop_count", dropCount, 32'd1);
    checkOutput("ovf_frag_count", fragCount, 32'd4);
`else
    checkOutput("ovf_drop_count_off", dropCount, 32'd0);
    checkOutput("ovf_frag_count_off", fragCount, 32'd0);
`endif
    memBus.i_fb_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      checkOutput("ovf_drain_we",   32'(memBus.o_fb_we),   32'd1);
      checkOutput("ovf_drain_addr", 32'(memBus.o_fb_addr), 32'(330 + k));
      checkOutput("ovf_drain_data", 32'(memBus.o_fb_data), 32'(k));
      tick();
    end
    checkOutput("ovf_drained_we", 32'(memBus.o_fb_we), 32'd0);
    checkOutput("ovf_drained_full", 32'(full), 32'd0);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
`ifdef FRAGMENT_WRITER_STATS_EN
    checkOutput("ovf_frag_count_end", fragCount, 32'd13);
`endif
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    tick();
    checkOutput("ovf_cleared_by_rst", 32'(overflow), 32'd0);
    checkOutput("rst2_drop_count",    dropCount,     32'd0);

    // Clear requested while two fragments (967, 968) are pending.
    memBus.i_fb_ready = 1'b0;
    applyStimulus(1'b1, 16'd3, 16'd7, 32'h0002_0000, 8'hA1);
    tick();
    applyStimulus(1'b1, 16'd3, 16'd8, 32'h0003_0000, 8'hA2);
    tick();
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0, 8'h00);
    clear      = 1'b1;
    clearColor = 8'h55;
    tick();
    clear      = 1'b0;
    clearColor = 8'h00;
    checkOutput("clr_busy",    32'(busy),             32'd1);
    checkOutput("clr_f1_addr", 32'(memBus.o_fb_addr), 32'd967);
    checkOutput("clr_f1_data", 32'(memBus.o_fb_data), 32'hA1);
    memBus.i_fb_ready = 1'b1;
    tick();
    checkOutput("clr_f2_addr",  32'(memBus.o_fb_addr), 32'd968);
    checkOutput("clr_f2_data",  32'(memBus.o_fb_data), 32'hA2);
    checkOutput("clr_f2_zdata", memBus.o_zb_data,      32'h0003_0000);
    tick();
    checkOutput("clr_first_addr", 32'(memBus.o_fb_addr), 32'd0);
    checkOutput("clr_first_data", 32'(memBus.o_fb_data), 32'h55);
    for (int i = 0; i < 76800; i++) begin
      if (memBus.o_fb_we !== 1'b1 || memBus.o_zb_we !== 1'b1 ||
          memBus.o_fb_addr !== 17'(i) || memBus.o_zb_addr !== 17'(i) ||
          memBus.o_fb_data !== 8'h55 || memBus.o_zb_data !== 32'd0 || busy !== 1'b1)
        sweepErrs++;
      if (i == 76799) checkOutput("clr_last_addr", 32'(memBus.o_fb_addr), 32'd76799);
      if (i < 76799) tick();
    end
    checkOutput("clr_sweep_errors", 32'(sweepErrs), 32'd0);
    tick();
    checkOutput("clr_done_we",   32'(memBus.o_fb_we), 32'd0);
    checkOutput("clr_done_busy", 32'(busy),           32'd0);
`ifdef FRAGMENT_WRITER_STATS_EN
    checkOutput("clr_frag_count", fragCount, 32'd2);
`endif

    // Off-screen fragment at x=320 is discarded silently.
    applyStimulus(1'b1, 16'd0, 16'd320, 32'd9, 8'h77);
    tick();
    applyStimulus(1'b0, 16'd0, 16'd0, 32'd0, 8'h00);
    checkOutput("oob_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("oob_we", 32'(memBus.o_fb_we), 32'd0);
    tick();
    checkOutput("oob_we2",      32'(memBus.o_fb_we), 32'd0);
    checkOutput("oob_overflow", 32'(overflow),       32'd0);
    checkOutput("oob_drop_count", dropCount,         32'd0);

    // Reset in the middle of a clear, while address 1000 is on the bus.
    clear      = 1'b1;
    clearColor = 8'hAA;
    tick();
    clear      = 1'b0;
    while (!(memBus.o_fb_we === 1'b1 && memBus.o_fb_addr === 17'd1000) && waitCycles < 3000) begin
      tick();
      waitCycles++;
    end
    checkOutput("midclr_reached_1000", 32'(waitCycles < 3000), 32'd1);
    checkOutput("midclr_data", 32'(memBus.o_fb_data), 32'hAA);
    rstN = 1'b0;
    tick();
    checkOutput("midclr_we_falls", 32'(memBus.o_fb_we), 32'd0);
    rstN = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (memBus.o_fb_we !== 1'b0) strayWrites++;
    end
    checkOutput("midclr_no_writes", 32'(strayWrites), 32'd0);
    checkOutput("midclr_busy",      32'(busy),        32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fragment_writer.md
# fragment_writer

Consumes the per-pixel fragment stream emitted by the rasterizer (write strobe, packed `{y, x}` point, 1/z value) and commits each fragment to the framebuffer and the zbuffer memories. It sits between the rasterizer output and the memory ports. It buffers fragments in a small FIFO to absorb framebuffer stalls, and it provides a full-screen clear sweep at frame start.

## Interface
- `SCREEN_WIDTH`, 320, pixels per line.
- `SCREEN_HEIGHT`, 240, lines per frame.
- `FIFO_DEPTH`, 8, fragment FIFO entries; must be a power of 2 and at least 2.
- `COLOR_W`, 8, framebuffer pixel width.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_clear`  in  1  one-cycle pulse; requests a full-screen clear.
- `i_clear_color`  in  COLOR_W  color written by the clear; sampled with `i_clear`.
- `i_write`  in  1  fragment valid (rasterizer `o_write`); no backpressure at the source.
- `i_point`  in  32  `{y[15:0], x[15:0]}`, unsigned integer pixel coordinates.
- `i_zdata`  in  32  1/z, 16.16 fixed point.
- `i_color`  in  COLOR_W  fragment color.
- `o_fb_addr`  out  17  framebuffer word address.
- `o_fb_data`  out  COLOR_W  framebuffer write data.
- `o_fb_we`  out  1  framebuffer write valid; held until accepted.
- `i_fb_ready`  in  1  framebuffer accepts the write in the current cycle.
- `o_zb_addr`  out  17  zbuffer address; always equal to `o_fb_addr`.
- `o_zb_data`  out  32  zbuffer write data.
- `o_zb_we`  out  1  zbuffer write; always equal to `o_fb_we`.
- `o_full`  out  1  FIFO full.
- `o_overflow`  out  1  sticky; set when a fragment is dropped.
- `o_busy`  out  1  high when the FIFO is non-empty, a clear is pending or running, or an output write is outstanding.
- `o_frag_count`  out  32  statistics output; see Configuration.
- `o_drop_count`  out  32  statistics output; see Configuration.

## Operation
Address computation:
- Address is `y*SCREEN_WIDTH + x`, truncated to 17 bits.
- A fragment with `x >= SCREEN_WIDTH` or `y >= SCREEN_HEIGHT` is discarded at enqueue. It is not counted as a drop and does not set `o_overflow`.

Enqueue:
- A fragment is pushed when `i_write` is high and the FIFO is not full.
- If `i_write` is high while the FIFO is full, the fragment is dropped and `o_overflow` is set. `o_overflow` clears only on reset.

Output register:
- The output is a single register slot (`o_fb_*` / `o_zb_*`).
- The slot loads from the FIFO head when it is empty, or when its current write is accepted (`o_fb_we && i_fb_ready`) in the same cycle.
- Push and pop may occur in the same cycle; FIFO occupancy is then unchanged.

States:
- `S_IDLE`: drain the FIFO. Any accepted `i_clear` latches `clear_pending` and the clear color. A second `i_clear` while one is pending or running is ignored.
- `S_IDLE -> S_CLEAR`: taken when `clear_pending` is set, the FIFO is empty, and the output slot is empty or being accepted.
- `S_CLEAR`: sweeps address 0 .. `SCREEN_WIDTH*SCREEN_HEIGHT-1`, writing the clear color to the framebuffer and 0 to the zbuffer. The address advances only on acceptance.
  - Fragments arriving during the clear are still enqueued, or dropped if the FIFO is full.
- `S_CLEAR -> S_IDLE`: taken on acceptance of the last address; `clear_pending` is cleared.

## Timing
- Reset values: every output is 0, FIFO empty, state `S_IDLE`, `clear_pending` 0, counters 0.
- Reset asserted mid-clear or mid-drain abandons all work immediately; no further writes are issued.
- Latency: a fragment presented in cycle N, with the FIFO and slot empty, produces `o_fb_we` = 1 in cycle N+2.
- Throughput: one write per cycle while `i_fb_ready` = 1.
- Stall: while `o_fb_we` = 1 and `i_fb_ready` = 0, the address and data outputs hold stable.
- Ordering: fragments are written in arrival order.
- Clear length: the clear takes exactly 76800 accepted writes at the default parameters.

## Configuration
- `FRAGMENT_WRITER_STATS_EN` defined:
  - `o_frag_count` increments on each accepted fragment write (clear writes excluded).
  - `o_drop_count` increments on each overflow drop.
  - Both counters saturate at `32'hFFFFFFFF`.
- `FRAGMENT_WRITER_STATS_EN` undefined: both ports are tied to 0 and no counter logic is synthesized.

## Structure
- Shared package `gfx_pkg`:
  - `SCREEN_WIDTH` and `SCREEN_HEIGHT` defaults.
  - `FB_ADDR_W` = 17.
  - `ZB_CLEAR_VALUE` = 0.
  - The writer state enum.
  - A packed fragment typedef `{addr[16:0], z[31:0], color}`.
- Sub-module `fragment_fifo`: synchronous FIFO with `push`, `pop`, `full`, `empty`. The address multiply happens before the push, so the FIFO stores the packed fragment typedef.

## Test plan
1. Reset with inputs toggling -> all outputs 0, `o_busy` 0, no write strobes.
2. Single fragment: `i_point` = `{16'd2, 16'd5}`, `i_zdata` = `32'h0001_0000`, `i_color` = `8'h3C`, `i_fb_ready` = 1 -> two cycles later, for exactly one cycle: `o_fb_we` = 1, `o_fb_addr` = 645, `o_fb_data` = `8'h3C`, `o_zb_data` = `32'h0001_0000`.
3. Backpressure: 3 fragments (x = 1, 2, 3; y = 0) with `i_fb_ready` low for 5 cycles -> `o_fb_addr` holds at 1; after release, addresses 1, 2, 3 are written on consecutive cycles.
4. Overflow: 10 back-to-back fragments with `i_fb_ready` = 0 -> `o_full` = 1 and `o_overflow` = 1.
   - Exactly one fragment sits in the output slot and 8 in the FIFO; the 10th is dropped.
   - `o_drop_count` = 1 when the macro is defined.
5. Clear: `i_clear` with `i_clear_color` = `8'h55` while 2 fragments are queued -> the 2 fragments are written first, then 76800 writes to addresses 0..76799 with data `8'h55` and zbuffer data 0. `o_busy` falls one cycle after the last acceptance.
6. Out-of-bounds fragment `{16'd0, 16'd320}` -> no write, `o_overflow` stays 0; reset mid-clear at address 1000 -> the write strobe falls at once and no further writes occur.
